fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID register directly upstream of the control unit.
- Owns the PC and drives a single-outstanding request/valid handshake to instruction memory.
- Presents the fetched word, its 6-bit op_code and PC+4 to decode.
- Handles decode stall, and branch/jump redirects that flush in-flight and buffered fetches.

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : PC owner, single-outstanding imem fetch, skid buffer, IF/ID.
// Optional macro FETCH_PERF_EN adds fetch/discard counters.   Rev 1.0
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] instr,
  output logic [5:0]  op_code,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    FULL    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] fetch_addr, fetch_addr_nxt;
  logic [31:0] instr_nxt, pc_plus4_nxt;
  logic        instr_valid_nxt, req_nxt;
  logic [31:0] skid_instr, skid_instr_nxt;
  logic [31:0] skid_pc4, skid_pc4_nxt;

  logic        redirect;
  logic        accept;
  logic [31:0] target;
  logic [31:0] fetch_addr_p4;

  assign redirect      = jump | branch_taken;
  assign target        = jump ? {pc_plus4[31:28], jump_index, 2'b00} : branch_target;
  assign accept        = !(instr_valid && stall);
  assign fetch_addr_p4 = fetch_addr + 32'd4;
  assign imem_addr     = fetch_addr;
  assign op_code       = instr[31:26];

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    fetch_addr_nxt  = fetch_addr;
    instr_nxt       = instr;
    pc_plus4_nxt    = pc_plus4;
    instr_valid_nxt = instr_valid;
    skid_instr_nxt  = skid_instr;
    skid_pc4_nxt    = skid_pc4;

    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (imem_valid) begin
          // The response is consumed either into IF/ID or into the skid.
          pc_nxt         = pc + 32'd4;
          fetch_addr_nxt = fetch_addr_p4;
          if (accept) begin
            instr_nxt       = imem_rdata;
            pc_plus4_nxt    = fetch_addr_p4;
            instr_valid_nxt = 1'b1;
          end else begin
            skid_instr_nxt = imem_rdata;
            skid_pc4_nxt   = fetch_addr_p4;
            state_nxt      = FULL;
          end
        end else if (accept) begin
          instr_valid_nxt = 1'b0;
        end
      end
      FULL: begin
        if (!stall) begin
          instr_nxt       = skid_instr;
          pc_plus4_nxt    = skid_pc4;
          instr_valid_nxt = 1'b1;
          state_nxt       = FETCH;
        end
      end
      DISCARD: begin
        if (imem_valid) begin
          fetch_addr_nxt = pc;
          state_nxt      = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase

    // Redirect overrides everything; an outstanding request must still complete.
    if (redirect) begin
      instr_nxt       = '0;
      instr_valid_nxt = 1'b0;
      skid_instr_nxt  = '0;
      skid_pc4_nxt    = '0;
      pc_nxt          = target;
      if ((state == FETCH || state == DISCARD) && !imem_valid) begin
        fetch_addr_nxt = fetch_addr;
        state_nxt      = DISCARD;
      end else begin
        fetch_addr_nxt = target;
        state_nxt      = FETCH;
      end
    end

    req_nxt = (state_nxt == FETCH) || (state_nxt == DISCARD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_addr  <= RESET_PC;
      instr       <= '0;
      pc_plus4    <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      skid_instr  <= '0;
      skid_pc4    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_addr  <= fetch_addr_nxt;
      instr       <= instr_nxt;
      pc_plus4    <= pc_plus4_nxt;
      instr_valid <= instr_valid_nxt;
      imem_req    <= req_nxt;
      skid_instr  <= skid_instr_nxt;
      skid_pc4    <= skid_pc4_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  logic load_ifid;
  logic drop_rsp;

  assign load_ifid = !redirect &&
                     ((state == FETCH && imem_valid && accept) || (state == FULL && !stall));
  assign drop_rsp  = imem_valid &&
                     ((state == DISCARD) || (state == FETCH && redirect));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt   <= '0;
      perf_discard_cnt <= '0;
    end else begin
      if (load_ifid) perf_fetch_cnt   <= perf_fetch_cnt + 32'd1;
      if (drop_rsp)  perf_discard_cnt <= perf_discard_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Bench for fetch_stage: directed scenarios, then randomized traffic checked
// against an expected-address-stream model with a wait-state memory responder.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] instr;
  logic [5:0]  op_code;
  logic [31:0] pc_plus4;
  logic        instr_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_discard_cnt;
`endif

  int          checks = 0;
  int          failures = 0;
  int          nconsumed = 0;
  logic [31:0] exp_addr;
  logic        n_stall, n_br, n_jmp;
  logic [31:0] n_tgt;
  logic [25:0] n_idx;
  int unsigned mem_max_wait;
  bit          mem_rand;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .instr        (instr),
    .op_code      (op_code),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_discard_cnt(perf_discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Unique, invertible word per address; top byte 0x8C for low addresses.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h8C5A_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Memory responder: fixed or random wait states, one response per request.
  initial begin : mem_model
    int unsigned wcnt, cur_wait;
    bit          busy;
    logic [31:0] req_addr;
    imem_valid = 1'b0;
    imem_rdata = '0;
    busy = 1'b0;
    wcnt = 0;
    cur_wait = 0;
    req_addr = '0;
    forever begin
      @(negedge clk);
      if (rst || !imem_req) begin
        imem_valid = 1'b0;
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = 0;
          req_addr = imem_addr;
          cur_wait = mem_rand ? $urandom_range(mem_max_wait, 0) : mem_max_wait;
        end else begin
          check("addr_stable", imem_addr, req_addr);
        end
        if (wcnt >= cur_wait) begin
          imem_valid = 1'b1;
          imem_rdata = word(imem_addr);
          busy = 1'b0;
        end else begin
          imem_valid = 1'b0;
          imem_rdata = $urandom;
          wcnt++;
        end
      end
    end
  end

  // One cycle: apply inputs, advance the expected stream, move to negedge+1.
  task automatic tick();
    logic [31:0] w;
    logic [31:0] plus4;
    stall         = n_stall;
    branch_taken  = n_br;
    branch_target = n_tgt;
    jump          = n_jmp;
    jump_index    = n_idx;
    if (!rst) begin
      plus4 = exp_addr + 32'd4;
      if (instr_valid && !n_stall) begin
        w = word(exp_addr);
        check("seq_instr", instr, w);
        check("seq_pc4", pc_plus4, plus4);
        check("seq_op", 32'(op_code), 32'(w[31:26]));
        nconsumed++;
        exp_addr = plus4;
      end
      if (n_jmp)     exp_addr = {plus4[31:28], n_idx, 2'b00};
      else if (n_br) exp_addr = n_tgt;
    end
    @(negedge clk);
    #1;
    n_stall = 1'b0;
    n_br    = 1'b0;
    n_jmp   = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d0;
    int          pulses;
    int          r;
    rst = 1'b1;
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_index = '0;
    n_stall = 1'b0; n_br = 1'b0; n_jmp = 1'b0; n_tgt = '0; n_idx = '0;
    mem_max_wait = 0; mem_rand = 1'b0;
    exp_addr = RST_PC;
    d0 = '0;

    // Reset values and zero-wait start-up
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc4", pc_plus4, 32'd0);
    check("rst_addr", imem_addr, RST_PC);
`ifdef FETCH_PERF_EN
    check("rst_perf_f", perf_fetch_cnt, 32'd0);
    check("rst_perf_d", perf_discard_cnt, 32'd0);
`endif
    rst = 1'b0;
    check("boot_req", 32'(imem_req), 32'd0);
    tick();
    check("zw_req", 32'(imem_req), 32'd1);
    check("zw_addr0", imem_addr, RST_PC);
    tick();
    check("zw_addr1", imem_addr, RST_PC + 32'd4);
    check("zw_valid", 32'(instr_valid), 32'd1);
    check("zw_pc4", pc_plus4, RST_PC + 32'd4);
    tick();
    check("zw_addr2", imem_addr, RST_PC + 32'd8);
    check("zw_pc4b", pc_plus4, RST_PC + 32'd8);

    // Two wait states: one instruction every three cycles
    mem_max_wait = 2;
    repeat (6) tick();
    for (int i = 0; i < 8 && !instr_valid; i++) tick();
    check("ws_valid", 32'(instr_valid), 32'd1);
    check("ws_op", 32'(op_code), 32'b100011);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (instr_valid) pulses++;
    end
    check("ws_rate", 32'(pulses), 32'd3);

    // Stall for 4 cycles with a response arriving
    mem_max_wait = 0;
    repeat (4) tick();
    for (int i = 0; i < 8 && !instr_valid; i++) tick();
    a = exp_addr;
    for (int i = 0; i < 4; i++) begin
      n_stall = 1'b1;
      tick();
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_hold", instr, word(a));
      check("stall_valid", 32'(instr_valid), 32'd1);
    end
    tick();
    check("skid_out", instr, word(a + 32'd4));
    check("skid_valid", 32'(instr_valid), 32'd1);
    tick();
    check("after_skid", instr, word(a + 32'd8));

    // Branch during an outstanding wait-state fetch of 0x20
    mem_max_wait = 2;
    n_br = 1'b1; n_tgt = 32'h0000_0020;
    tick();
    check("br1_flush", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (imem_req && imem_addr == 32'h20 && !imem_valid) break;
      tick();
    end
    check("br_wait_addr", imem_addr, 32'h0000_0020);
`ifdef FETCH_PERF_EN
    d0 = perf_discard_cnt;
`endif
    n_br = 1'b1; n_tgt = 32'h0000_0100;
    tick();
    check("br_flush_v", 32'(instr_valid), 32'd0);
    check("br_flush_i", instr, 32'd0);
    check("br_hold_req", 32'(imem_req), 32'd1);
    check("br_hold_addr", imem_addr, 32'h0000_0020);
    for (int i = 0; i < 10 && imem_addr == 32'h20; i++) tick();
    check("br_new_addr", imem_addr, 32'h0000_0100);
    check("br_new_req", 32'(imem_req), 32'd1);
`ifdef FETCH_PERF_EN
    check("br_perf_disc", perf_discard_cnt - d0, 32'd1);
`endif
    for (int i = 0; i < 8 && !instr_valid; i++) tick();
    check("br_landed", 32'(instr_valid), 32'd1);

    // Jump and branch together: jump wins
    mem_max_wait = 0;
    n_br = 1'b1; n_tgt = 32'h1000_0004;
    tick();
    for (int i = 0; i < 12 && !instr_valid; i++) tick();
    check("jmp_setup", pc_plus4, 32'h1000_0008);
    n_jmp = 1'b1; n_idx = 26'h000_0010; n_br = 1'b1; n_tgt = 32'h0000_0200;
    tick();
    check("jmp_addr", imem_addr, 32'h1000_0040);
    check("jmp_req", 32'(imem_req), 32'd1);

    // Asynchronous reset in the middle of a wait
    mem_max_wait = 3;
    repeat (3) tick();
    for (int i = 0; i < 12 && !instr_valid; i++) tick();
    n_stall = 1'b1;
    tick();
    check("rst_pre_req", 32'(imem_req), 32'd1);
    check("rst_pre_valid", 32'(instr_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_instr", instr, 32'd0);
    stall = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_addr = RST_PC;
    check("arst_boot", 32'(imem_req), 32'd0);
    tick();
    check("arst_req1", 32'(imem_req), 32'd1);
    check("arst_addr", imem_addr, RST_PC);

    // Randomized traffic against the address-stream model
    mem_rand = 1'b1;
    mem_max_wait = 3;
    for (int i = 0; i < 2000; i++) begin
      n_stall = ($urandom_range(99, 0) < 25);
      r = int'($urandom_range(99, 0));
      if (r < 3 && instr_valid) begin
        n_jmp = 1'b1;
        n_idx = 26'($urandom);
        n_br  = 1'($urandom_range(1, 0));
        n_tgt = 32'h0000_0300;
      end else if (r < 9) begin
        n_br = 1'b1;
        if ($urandom_range(4, 0) == 0)
          n_tgt = 32'hFFFF_FFF0 + 32'($urandom_range(3, 0)) * 32'd4;
        else
          n_tgt = {20'd0, 10'($urandom_range(1023, 0)), 2'b00};
      end
      tick();
    end
    check("progress", 32'(nconsumed >= 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
